color_ident_encoder: RTL and testbench

//  Reverse of the ident-to-colour resolution: maps a resolved 32-bit ARGB colour back to the
//  CSS value ident (10-bit) of the first matching named/system colour, for computed-style

---
 rtl/color_ident_encoder_if.sv | 33 +++
 rtl/color_ident_encoder.sv | 177 +++++++++++++++++
 tb/tb_color_ident_encoder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_ident_encoder_if.sv
// color_ident_encoder_if: table-write, request and response signals of the
// colour-to-ident encoder, grouped so producer and encoder share one bundle.
interface color_ident_encoder_if #(
  parameter int IDX_W   = 6,
  parameter int IDENT_W = 10,
  parameter int COLOR_W = 32
);
  logic               tbl_wr_en;
  logic [IDX_W-1:0]   tbl_wr_idx;
  logic [IDENT_W-1:0] tbl_wr_ident;
  logic [COLOR_W-1:0] tbl_wr_color;
  logic               tbl_clear;
  logic               tbl_wr_ready;
  logic               req_valid;
  logic               req_ready;
  logic [COLOR_W-1:0] req_color;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDENT_W-1:0] rsp_ident;
  logic               rsp_hit;

  modport master (
    output tbl_wr_en, tbl_wr_idx, tbl_wr_ident, tbl_wr_color, tbl_clear,
    output req_valid, req_color, rsp_ready,
    input  tbl_wr_ready, req_ready, rsp_valid, rsp_ident, rsp_hit
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_idx, tbl_wr_ident, tbl_wr_color, tbl_clear,
    input  req_valid, req_color, rsp_ready,
    output tbl_wr_ready, req_ready, rsp_valid, rsp_ident, rsp_hit
  );
endinterface

// File: rtl/color_ident_encoder.sv
// color_ident_encoder: maps a resolved ARGB colour back to the CSS value ident
// of the first (lowest-index) matching entry of a software-loaded table.
// The table is scanned one entry per cycle; ident 0 in a response means "no name".
// Optional feature: define COLOR_IDENT_LAST_HIT_CACHE_EN to add a one-entry
// last-hit cache that answers a repeated colour without rescanning.
module color_ident_encoder #(
  parameter int DEPTH   = 40,
  parameter int IDX_W   = 6,
  parameter int IDENT_W = 10,
  parameter int COLOR_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  color_ident_encoder_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COLOR_W-1:0] color_lat_q, color_lat_d;
  logic [IDENT_W-1:0] rsp_ident_q, rsp_ident_d;
  logic               rsp_hit_q, rsp_hit_d;

  // Table lives in flops so the scan compare can read an entry combinationally.
  logic [DEPTH-1:0]   ent_vld_q, ent_vld_d;
  logic [IDENT_W-1:0] ent_ident_q [DEPTH];
  logic [IDENT_W-1:0] ent_ident_d [DEPTH];
  logic [COLOR_W-1:0] ent_color_q [DEPTH];
  logic [COLOR_W-1:0] ent_color_d [DEPTH];

  logic is_idle;
  logic clr_acc;
  logic wr_acc;
  logic entry_match;
  logic last_entry;

  assign is_idle     = (state_q == ST_IDLE);
  assign clr_acc     = is_idle && bus.tbl_clear;
  assign wr_acc      = is_idle && bus.tbl_wr_en && !bus.tbl_clear &&
                       ({1'b0, bus.tbl_wr_idx} < (IDX_W+1)'(DEPTH));
  assign entry_match = ent_vld_q[idx_q] && (ent_color_q[idx_q] == color_lat_q);
  assign last_entry  = (idx_q == IDX_W'(DEPTH-1));

  assign bus.tbl_wr_ready = is_idle;
  assign bus.req_ready    = is_idle;
  assign bus.rsp_valid    = (state_q == ST_RESP);
  assign bus.rsp_ident    = rsp_ident_q;
  assign bus.rsp_hit      = rsp_hit_q;

`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
  logic               cache_vld_q, cache_vld_d;
  logic [COLOR_W-1:0] cache_color_q, cache_color_d;
  logic [IDENT_W-1:0] cache_ident_q, cache_ident_d;
  logic               cache_hit;

  // A table change in the acceptance cycle must not be bypassed by a stale cache line.
  assign cache_hit = cache_vld_q && !(clr_acc || wr_acc) && (bus.req_color == cache_color_q);
`endif

  // Next table contents: clear beats write; ident 0 stores the entry as invalid.
  always_comb begin
    ent_vld_d   = ent_vld_q;
    ent_ident_d = ent_ident_q;
    ent_color_d = ent_color_q;
    if (clr_acc) begin
      ent_vld_d = '0;
    end else if (wr_acc) begin
      ent_vld_d[bus.tbl_wr_idx]   = (bus.tbl_wr_ident != '0);
      ent_ident_d[bus.tbl_wr_idx] = bus.tbl_wr_ident;
      ent_color_d[bus.tbl_wr_idx] = bus.tbl_wr_color;
    end
  end

  // Next-state and response logic: accept in IDLE, walk the table in SCAN, hold in RESP.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    color_lat_d = color_lat_q;
    rsp_ident_d = rsp_ident_q;
    rsp_hit_d   = rsp_hit_q;
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
    cache_vld_d   = cache_vld_q;
    cache_color_d = cache_color_q;
    cache_ident_d = cache_ident_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          color_lat_d = bus.req_color;
          idx_d       = '0;
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
          if (cache_hit) begin
            state_d     = ST_RESP;
            rsp_hit_d   = 1'b1;
            rsp_ident_d = cache_ident_q;
          end else begin
            state_d = ST_SCAN;
          end
`else
          state_d = ST_SCAN;
`endif
        end
      end
      ST_SCAN: begin
        if (entry_match) begin
          state_d     = ST_RESP;
          rsp_hit_d   = 1'b1;
          rsp_ident_d = ent_ident_q[idx_q];
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
          cache_vld_d   = 1'b1;
          cache_color_d = color_lat_q;
          cache_ident_d = ent_ident_q[idx_q];
`endif
        end else if (last_entry) begin
          state_d     = ST_RESP;
          rsp_hit_d   = 1'b0;
          rsp_ident_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
    if (clr_acc || wr_acc) begin
      cache_vld_d = 1'b0;
    end
`endif
  end

  // Control and response registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      color_lat_q <= '0;
      rsp_ident_q <= '0;
      rsp_hit_q   <= 1'b0;
      ent_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      color_lat_q <= color_lat_d;
      rsp_ident_q <= rsp_ident_d;
      rsp_hit_q   <= rsp_hit_d;
      ent_vld_q   <= ent_vld_d;
    end
  end

  // Entry payload needs no reset: it is only observed through its valid bit.
  always_ff @(posedge clk) begin
    ent_ident_q <= ent_ident_d;
    ent_color_q <= ent_color_d;
  end

`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
  // Last-hit cache line, emptied by reset and by any accepted table change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q   <= 1'b0;
      cache_color_q <= '0;
      cache_ident_q <= '0;
    end else begin
      cache_vld_q   <= cache_vld_d;
      cache_color_q <= cache_color_d;
      cache_ident_q <= cache_ident_d;
    end
  end
`endif

endmodule

// File: tb/tb_color_ident_encoder.sv
// tb_color_ident_encoder: directed scenarios for the colour-to-ident encoder.
// Latency is counted in clock edges from the request acceptance edge.
module tb_color_ident_encoder;

  localparam int DEPTH = 40;
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  // Expected state of the last-hit cache (only consulted when the cache is built in).
  bit          m_cache_vld = 1'b0;
  logic [31:0] m_cache_color = '0;

  color_ident_encoder_if bus ();

  color_ident_encoder #(
    .DEPTH(DEPTH), .IDX_W(6), .IDENT_W(10), .COLOR_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] c, input int scan_lat);
    if (CACHE_EN && m_cache_vld && (c == m_cache_color)) return 1;
    return scan_lat;
  endfunction

  task automatic note_hit(input logic [31:0] c);
    m_cache_vld   = 1'b1;
    m_cache_color = c;
  endtask

  task automatic idle_inputs();
    bus.tbl_wr_en    = 1'b0;
    bus.tbl_wr_idx   = '0;
    bus.tbl_wr_ident = '0;
    bus.tbl_wr_color = '0;
    bus.tbl_clear    = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_color    = '0;
    bus.rsp_ready    = 1'b0;
  endtask

  task automatic write_entry(input logic [5:0] idx, input logic [9:0] ident, input logic [31:0] color);
    bus.tbl_wr_en    = 1'b1;
    bus.tbl_wr_idx   = idx;
    bus.tbl_wr_ident = ident;
    bus.tbl_wr_color = color;
    @(posedge clk);
    #1 bus.tbl_wr_en = 1'b0;
    if (idx < 6'(DEPTH)) m_cache_vld = 1'b0;
  endtask

  task automatic load_table();
    write_entry(6'd0, 10'h2A1, 32'hFF00FFFF);
    write_entry(6'd1, 10'h2A5, 32'hFF808080);
    write_entry(6'd2, 10'h2B0, 32'hFF808080);
  endtask

  task automatic wait_response(output int lat);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    lat = (bus.rsp_valid === 1'b1) ? n : -1;
  endtask

  task automatic start_lookup(input logic [31:0] color, output int lat);
    bus.req_valid = 1'b1;
    bus.req_color = color;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_response(lat);
  endtask

  task automatic ack_response();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_hit: got %b want 0", bus.rsp_hit); end
    total++; if (bus.rsp_ident !== 10'h000) begin bad++; $display("[TB] FAIL reset_rsp_ident: got %h want 000", bus.rsp_ident); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.tbl_wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tbl_wr_ready: got %b want 1", bus.tbl_wr_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hit();
    logic [31:0] col  [2] = '{32'hFF808080, 32'hFF00FFFF};
    logic [9:0]  idn  [2] = '{10'h2A5, 10'h2A1};
    int          scan [2] = '{2, 1};
    int lat, want;
    load_table();
    for (int i = 0; i < 2; i++) begin
      want = exp_lat(col[i], scan[i]);
      start_lookup(col[i], lat);
      total++; if (lat != want) begin bad++; $display("[TB] FAIL hit_latency[%0d]: got %0d want %0d", i, lat, want); end
      total++; if (bus.rsp_ident !== idn[i]) begin bad++; $display("[TB] FAIL hit_ident[%0d]: got %h want %h", i, bus.rsp_ident, idn[i]); end
      total++; if (bus.rsp_hit !== 1'b1) begin bad++; $display("[TB] FAIL hit_flag[%0d]: got %b want 1", i, bus.rsp_hit); end
      ack_response();
      note_hit(col[i]);
    end
  endtask

  task automatic test_miss();
    logic [31:0] col [2] = '{32'hFF123456, 32'hFF808081};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_lookup(col[i], lat);
      total++; if (lat != DEPTH) begin bad++; $display("[TB] FAIL miss_latency[%0d]: got %0d want %0d", i, lat, DEPTH); end
      total++; if (bus.rsp_ident !== 10'h000) begin bad++; $display("[TB] FAIL miss_ident[%0d]: got %h want 000", i, bus.rsp_ident); end
      total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("[TB] FAIL miss_flag[%0d]: got %b want 0", i, bus.rsp_hit); end
      ack_response();
    end
  endtask

  task automatic test_boundary();
    int lat, want;
    write_entry(6'd39, 10'h3FF, 32'h00000000);
    want = exp_lat(32'h00000000, DEPTH);
    start_lookup(32'h00000000, lat);
    total++; if (lat != want) begin bad++; $display("[TB] FAIL last_entry_latency: got %0d want %0d", lat, want); end
    total++; if (bus.rsp_ident !== 10'h3FF) begin bad++; $display("[TB] FAIL last_entry_ident: got %h want 3ff", bus.rsp_ident); end
    ack_response();
    note_hit(32'h00000000);

    write_entry(6'd45, 10'h111, 32'hFFABCDEF);
    start_lookup(32'hFFABCDEF, lat);
    total++; if (lat != DEPTH) begin bad++; $display("[TB] FAIL out_of_range_latency: got %0d want %0d", lat, DEPTH); end
    total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("[TB] FAIL out_of_range_hit: got %b want 0", bus.rsp_hit); end
    ack_response();

    write_entry(6'd1, 10'h2C0, 32'hFF808080);
    want = exp_lat(32'hFF808080, 2);
    start_lookup(32'hFF808080, lat);
    total++; if (lat != want) begin bad++; $display("[TB] FAIL overwrite_latency: got %0d want %0d", lat, want); end
    total++; if (bus.rsp_ident !== 10'h2C0) begin bad++; $display("[TB] FAIL overwrite_ident: got %h want 2c0", bus.rsp_ident); end
    ack_response();
    note_hit(32'hFF808080);

    write_entry(6'd1, 10'h000, 32'hFF808080);
    want = exp_lat(32'hFF808080, 3);
    start_lookup(32'hFF808080, lat);
    total++; if (lat != want) begin bad++; $display("[TB] FAIL invalidate_latency: got %0d want %0d", lat, want); end
    total++; if (bus.rsp_ident !== 10'h2B0) begin bad++; $display("[TB] FAIL invalidate_ident: got %h want 2b0", bus.rsp_ident); end
    ack_response();
    note_hit(32'hFF808080);
  endtask

  task automatic test_hold();
    int lat, want;
    want = exp_lat(32'hFF808080, 3);
    start_lookup(32'hFF808080, lat);
    total++; if (lat != want) begin bad++; $display("[TB] FAIL hold_latency: got %0d want %0d", lat, want); end
    for (int i = 0; i < 5; i++) begin
      bus.tbl_wr_en    = 1'b1;
      bus.tbl_wr_idx   = 6'd2;
      bus.tbl_wr_ident = 10'h155;
      bus.tbl_wr_color = 32'hFF808080;
      bus.req_valid    = 1'b1;
      bus.req_color    = 32'hFF00FFFF;
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      total++; if (bus.rsp_ident !== 10'h2B0) begin bad++; $display("[TB] FAIL hold_ident[%0d]: got %h want 2b0", i, bus.rsp_ident); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      @(posedge clk);
      #1;
    end
    bus.tbl_wr_en = 1'b0;
    bus.req_valid = 1'b0;
    ack_response();
    note_hit(32'hFF808080);
    want = exp_lat(32'hFF808080, 3);
    start_lookup(32'hFF808080, lat);
    total++; if (lat != want) begin bad++; $display("[TB] FAIL hold_readback_latency: got %0d want %0d", lat, want); end
    total++; if (bus.rsp_ident !== 10'h2B0) begin bad++; $display("[TB] FAIL hold_readback_ident: got %h want 2b0", bus.rsp_ident); end
    ack_response();
  endtask

  task automatic test_write_with_req();
    int lat;
    bus.tbl_wr_en    = 1'b1;
    bus.tbl_wr_idx   = 6'd3;
    bus.tbl_wr_ident = 10'h2D0;
    bus.tbl_wr_color = 32'hFF445566;
    bus.req_valid    = 1'b1;
    bus.req_color    = 32'hFF445566;
    @(posedge clk);
    #1 bus.tbl_wr_en = 1'b0;
    bus.req_valid = 1'b0;
    m_cache_vld = 1'b0;
    wait_response(lat);
    total++; if (lat != 4) begin bad++; $display("[TB] FAIL write_with_req_latency: got %0d want 4", lat); end
    total++; if (bus.rsp_ident !== 10'h2D0) begin bad++; $display("[TB] FAIL write_with_req_ident: got %h want 2d0", bus.rsp_ident); end
    ack_response();
    note_hit(32'hFF445566);
  endtask

  task automatic test_clear();
    logic [31:0] col [2] = '{32'hFF000000, 32'hFF00FFFF};
    int lat;
    bus.tbl_clear    = 1'b1;
    bus.tbl_wr_en    = 1'b1;
    bus.tbl_wr_idx   = 6'd0;
    bus.tbl_wr_ident = 10'h2A1;
    bus.tbl_wr_color = 32'hFF000000;
    @(posedge clk);
    #1 bus.tbl_clear = 1'b0;
    bus.tbl_wr_en = 1'b0;
    m_cache_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_lookup(col[i], lat);
      total++; if (lat != DEPTH) begin bad++; $display("[TB] FAIL clear_latency[%0d]: got %0d want %0d", i, lat, DEPTH); end
      total++; if (bus.rsp_ident !== 10'h000) begin bad++; $display("[TB] FAIL clear_ident[%0d]: got %h want 000", i, bus.rsp_ident); end
      total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("[TB] FAIL clear_hit[%0d]: got %b want 0", i, bus.rsp_hit); end
      ack_response();
    end
  endtask

  task automatic test_back_to_back();
    int lat, want;
    load_table();
    for (int i = 0; i < 2; i++) begin
      want = exp_lat(32'hFF808080, 2);
      start_lookup(32'hFF808080, lat);
      total++; if (lat != want) begin bad++; $display("[TB] FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, want); end
      total++; if (bus.rsp_ident !== 10'h2A5) begin bad++; $display("[TB] FAIL b2b_ident[%0d]: got %h want 2a5", i, bus.rsp_ident); end
      ack_response();
      note_hit(32'hFF808080);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    bit seen;
    bus.req_valid = 1'b1;
    bus.req_color = 32'hFF123456;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    m_cache_vld = 1'b0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midscan_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midscan_req_ready: got %b want 1", bus.req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midscan_dropped: got %b want 0", seen); end
    @(posedge clk);
    #1;
    start_lookup(32'hFF808080, lat);
    total++; if (lat != DEPTH) begin bad++; $display("[TB] FAIL midscan_empty_latency: got %0d want %0d", lat, DEPTH); end
    total++; if (bus.rsp_hit !== 1'b0) begin bad++; $display("[TB] FAIL midscan_empty_hit: got %b want 0", bus.rsp_hit); end
    ack_response();
  endtask

`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
  task automatic test_cache();
    int lat;
    int want [3] = '{2, 1, 2};
    load_table();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) write_entry(6'd5, 10'h123, 32'hFF010203);
      start_lookup(32'hFF808080, lat);
      total++; if (lat != want[i]) begin bad++; $display("[TB] FAIL cache_latency[%0d]: got %0d want %0d", i, lat, want[i]); end
      total++; if (bus.rsp_ident !== 10'h2A5) begin bad++; $display("[TB] FAIL cache_ident[%0d]: got %h want 2a5", i, bus.rsp_ident); end
      ack_response();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_boundary();
    test_hold();
    test_write_with_req();
    test_clear();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef COLOR_IDENT_LAST_HIT_CACHE_EN
    test_cache();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
